// File: rtl/correlator_channel.sv
// correlator_channel: one lag of the correlator.
// Multiplies the direct sample by the delayed sample from the delay line,
// accumulates the products and sample count, and on a dump request hands
// the totals to a valid/ack output register while restarting accumulation
// without losing any sample.
//
// Optional feature: define CORRELATOR_CHANNEL_SATURATE_EN to make the
// accumulator, the sample counter and the snapshot arithmetic clamp at
// their all-ones value instead of wrapping.
module correlator_channel #(
    parameter int DIM   = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [DIM-1:0]   direct_data,
    input  logic [DIM-1:0]   delayed_data,
    input  logic             dump,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             overrun
);

    localparam int PROD_W = 2 * DIM;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Stage 1: registered product plus the valid and dump markers that travel with it
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              v1_q, v1_d;
    logic              d1_q, d1_d;

    // Stage 2: running totals since the last dump
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Output snapshot register and its handshake state
    out_state_t        state_q, state_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              overrun_q, overrun_d;

    // Totals including the product currently sitting in stage 1
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;

    // High for the one edge in which stage 2 hands a snapshot to the output
    logic              snap_valid;

    // Stage 1: capture the product and markers of the incoming pair unless frozen
    always_comb begin
        prod_d = prod_q;
        v1_d   = v1_q;
        d1_d   = d1_q;
        if (!stall) begin
            prod_d = PROD_W'(direct_data) * PROD_W'(delayed_data);
            v1_d   = in_valid;
            d1_d   = dump;
        end
    end

`ifdef CORRELATOR_CHANNEL_SATURATE_EN
    localparam int ACC_SUM_W = ACC_W + 1;
    localparam int CNT_SUM_W = CNT_W + 1;

    logic [ACC_SUM_W-1:0] acc_sum;
    logic [CNT_SUM_W-1:0] cnt_sum;

    // Add the stage 1 product with one carry bit and clamp when it overflows
    always_comb begin
        acc_sum  = ACC_SUM_W'(acc_q) + (v1_q ? ACC_SUM_W'(prod_q) : '0);
        cnt_sum  = CNT_SUM_W'(cnt_q) + CNT_SUM_W'(v1_q);
        acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
`else
    // Add the stage 1 product, letting the totals wrap at their width
    always_comb begin
        acc_next = acc_q + (v1_q ? ACC_W'(prod_q) : '0);
        cnt_next = cnt_q + CNT_W'(v1_q);
    end
`endif

    // Stage 2: accumulate, or hand the totals off as a snapshot and restart from zero
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        snap_valid = 1'b0;
        if (!stall) begin
            if (d1_q) begin
                acc_d      = '0;
                cnt_d      = '0;
                snap_valid = 1'b1;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
            end
        end
    end

    // Output handshake: load into an empty slot, replace on a same-cycle ack, otherwise drop and flag
    always_comb begin
        state_d   = state_q;
        out_acc_d = out_acc_q;
        out_cnt_d = out_cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            OUT_EMPTY: begin
                if (snap_valid) begin
                    out_acc_d = acc_next;
                    out_cnt_d = cnt_next;
                    state_d   = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (snap_valid && out_ack) begin
                    out_acc_d = acc_next;
                    out_cnt_d = cnt_next;
                end else if (snap_valid) begin
                    overrun_d = 1'b1;
                end else if (out_ack) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
    end

    // State registers; clr wipes the pipeline, any pending snapshot and the output
    always_ff @(posedge clk) begin
        if (clr) begin
            prod_q    <= '0;
            v1_q      <= 1'b0;
            d1_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= OUT_EMPTY;
            out_acc_q <= '0;
            out_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            v1_q      <= v1_d;
            d1_q      <= d1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            out_acc_q <= out_acc_d;
            out_cnt_q <= out_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_correlator_channel.sv
// tb_correlator_channel: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the channel.
// The accumulator is 32 bits wide here so wrap/clamp behaviour is reachable.
module tb_correlator_channel;

    localparam int DIM   = 16;
    localparam int ACC_W = 32;
    localparam int CNT_W = 32;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic             clk = 1'b0;
    logic             clr;
    logic             stall;
    logic             in_valid;
    logic [DIM-1:0]   direct_data;
    logic [DIM-1:0]   delayed_data;
    logic             dump;
    logic             out_valid;
    logic             out_ack;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             overrun;

    int errorCount = 0;
    int checkCount = 0;

    // Model: totals of accepted samples since the last accepted dump,
    // a snapshot waiting for its next unstalled edge, and the output register
    longint unsigned runSum  = 0;
    longint unsigned runCnt  = 0;
    logic            pendValid = 1'b0;
    longint unsigned pendSum = 0;
    longint unsigned pendCnt = 0;
    logic             mValid   = 1'b0;
    logic             mOverrun = 1'b0;
    logic [ACC_W-1:0] mAcc     = '0;
    logic [CNT_W-1:0] mCnt     = '0;

    always #5 clk = ~clk;

    correlator_channel #(
        .DIM   (DIM),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .stall        (stall),
        .in_valid     (in_valid),
        .direct_data  (direct_data),
        .delayed_data (delayed_data),
        .dump         (dump),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .out_acc      (out_acc),
        .out_cnt      (out_cnt),
        .overrun      (overrun)
    );

    // Reduce an exact total to the output width: clamp or wrap
    function automatic logic [ACC_W-1:0] finAcc(input longint unsigned s);
`ifdef CORRELATOR_CHANNEL_SATURATE_EN
        if (s > ACC_MAX) return '1;
`endif
        return ACC_W'(s);
    endfunction

    function automatic logic [CNT_W-1:0] finCnt(input longint unsigned s);
`ifdef CORRELATOR_CHANNEL_SATURATE_EN
        if (s > CNT_MAX) return '1;
`endif
        return CNT_W'(s);
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    function void modelEdge();
        logic            arrive;
        longint unsigned aSum;
        longint unsigned aCnt;
        if (clr) begin
            runSum = 0; runCnt = 0; pendValid = 1'b0;
            mValid = 1'b0; mOverrun = 1'b0; mAcc = '0; mCnt = '0;
            return;
        end
        arrive = pendValid && !stall;
        aSum   = pendSum;
        aCnt   = pendCnt;
        if (arrive) pendValid = 1'b0;
        if (in_valid && !stall) begin
            runSum += longint'(direct_data) * longint'(delayed_data);
            runCnt += 1;
        end
        if (dump && !stall) begin
            pendValid = 1'b1;
            pendSum   = runSum;
            pendCnt   = runCnt;
            runSum    = 0;
            runCnt    = 0;
        end
        if (arrive) begin
            if (!mValid || out_ack) begin
                mValid = 1'b1;
                mAcc   = finAcc(aSum);
                mCnt   = finCnt(aCnt);
            end else begin
                mOverrun = 1'b1;
            end
        end else if (out_ack) begin
            mValid = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model
    task automatic applyStimulus(input logic c, input logic st, input logic iv,
                                 input logic [DIM-1:0] dd, input logic [DIM-1:0] dl,
                                 input logic dp, input logic ak);
        clr = c; stall = st; in_valid = iv;
        direct_data = dd; delayed_data = dl; dump = dp; out_ack = ak;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("out_valid", out_valid, mValid);
        checkOutput("out_acc",   out_acc,   mAcc);
        checkOutput("out_cnt",   out_cnt,   mCnt);
        checkOutput("overrun",   overrun,   mOverrun);
    endtask

    task automatic idle(input int n, input logic ak);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, ak);
    endtask

    initial begin
        logic [DIM-1:0] a, b;

        $display("[TB] basic correlation");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("resetValid", out_valid, 0);
        checkOutput("resetAcc", out_acc, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 3, 5, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("basicEarlyValid", out_valid, 0);
        idle(1, 0);
        checkOutput("basicValid", out_valid, 1);
        checkOutput("basicAcc", out_acc, 60);
        checkOutput("basicCnt", out_cnt, 4);
        checkOutput("basicOverrun", overrun, 0);
        idle(5, 0);
        checkOutput("basicHeldAcc", out_acc, 60);
        idle(1, 1);
        checkOutput("basicAckValid", out_valid, 0);

        $display("[TB] same-cycle dump and stall");
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 7, 7, 1, 0);
        idle(1, 0);
        checkOutput("sameAcc", out_acc, 51);
        checkOutput("sameCnt", out_cnt, 3);
        idle(1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        checkOutput("emptyValid", out_valid, 1);
        checkOutput("emptyAcc", out_acc, 0);
        checkOutput("emptyCnt", out_cnt, 0);
        idle(1, 1);
        applyStimulus(0, 0, 1, 2, 2, 0, 0);
        applyStimulus(0, 0, 1, 2, 2, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 9, 9, 1, 0);
        applyStimulus(0, 0, 1, 2, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        checkOutput("stallAcc", out_acc, 12);
        checkOutput("stallCnt", out_cnt, 3);
        idle(1, 1);

        $display("[TB] overrun");
        applyStimulus(0, 0, 1, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(4, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        checkOutput("ovrFlag", overrun, 1);
        checkOutput("ovrKeptAcc", out_acc, 2);
        checkOutput("ovrKeptCnt", out_cnt, 1);
        applyStimulus(0, 0, 1, 3, 3, 1, 0);
        idle(1, 1);
        checkOutput("ovrReloadValid", out_valid, 1);
        checkOutput("ovrReloadAcc", out_acc, 9);
        checkOutput("ovrReloadCnt", out_cnt, 1);
        idle(1, 1);
        checkOutput("ovrSticky", overrun, 1);

        $display("[TB] saturation boundary");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("ovrCleared", overrun, 0);
        applyStimulus(0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0);
        applyStimulus(0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
`ifdef CORRELATOR_CHANNEL_SATURATE_EN
        checkOutput("satAcc", out_acc, 32'hFFFFFFFF);
`else
        checkOutput("wrapAcc", out_acc, 32'hFFFC0002);
`endif
        checkOutput("satCnt", out_cnt, 2);
        idle(1, 1);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 0, 1, 4, 4, 1, 0);
        idle(1, 0);
        applyStimulus(0, 0, 1, 5, 5, 1, 0);
        applyStimulus(1, 0, 1, 6, 6, 1, 1);
        checkOutput("clrValid", out_valid, 0);
        checkOutput("clrAcc", out_acc, 0);
        checkOutput("clrCnt", out_cnt, 0);
        idle(4, 0);
        checkOutput("clrNoSnap", out_valid, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) < 7,
                          a, b,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 3);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/correlator_channel.md
# correlator_channel

- Single lag channel of the correlator; sits directly downstream of the per-lag delay line.
- Each cycle it multiplies the current (direct) sample by the delayed sample from the delay line and accumulates the product into a wide register.
- On request it snapshots the accumulated correlation and the sample count into output registers, presented under a valid/ack handshake, and restarts accumulation from zero without losing samples.

## Interface
Parameters:
- DIM, 16, width of direct and delayed samples (unsigned)
- ACC_W, 48, accumulator and out_acc width; must be ≥ 2*DIM
- CNT_W, 32, sample counter and out_cnt width

Ports:
- clk  in  1  clock; everything is on its rising edge
- clr  in  1  reset, synchronous, active-high
- stall  in  1  freezes the whole pipeline, same meaning as the delay line stall
- in_valid  in  1  a sample pair is present this cycle
- direct_data  in  DIM  current sample
- delayed_data  in  DIM  delay line out_data for this lag
- dump  in  1  snapshot request, one-cycle strobe
- out_valid  out  1  snapshot available
- out_ack  in  1  consumer takes the snapshot
- out_acc  out  ACC_W  snapshot of accumulated products
- out_cnt  out  CNT_W  snapshot of accepted sample count
- overrun  out  1  sticky: a snapshot was dropped

## Operation
Pipeline:
- Stage 1 register: prod = direct_data*delayed_data (2*DIM bits, unsigned), v1 = in_valid, d1 = dump.
- Stage 2 register: acc, cnt.
- A sample is accepted when in_valid=1 and stall=0.
- A dump is accepted when dump=1 and stall=0; dump while stall=1 is ignored.
- Stage 2 with d1=0: acc += v1 ? prod : 0; cnt += v1.
- Stage 2 with d1=1:
  - The snapshot is acc + (v1 ? prod : 0) and cnt + v1. It therefore includes a sample accepted in the same cycle as the dump.
  - acc and cnt are then set to 0.

Output handshake, two states:
- EMPTY (out_valid=0): a snapshot loads out_acc/out_cnt, then go to FULL.
- FULL (out_valid=1):
  - out_ack=1 with no snapshot: go to EMPTY.
  - out_ack=1 with a snapshot in the same cycle: load the new snapshot and stay FULL.
  - Snapshot with out_ack=0: drop the snapshot, set overrun=1, keep the old out_acc/out_cnt. acc/cnt are still cleared.
- out_acc/out_cnt are stable while out_valid=1 and are only changed by a load.
- out_ack is honoured regardless of stall.
- overrun is cleared only by clr.

Reset:
- clr=1 zeroes prod, v1, d1, acc, cnt, out_acc, out_cnt, out_valid and overrun in that cycle.
- clr overrides stall, in_valid, dump and out_ack.
- A pending snapshot is discarded.

## Timing
- Latency: sample accepted at edge n → prod at n+1 → included in acc at n+2.
- Dump accepted at edge n → out_valid=1 after edge n+2 (if EMPTY).
- stall=1 holds prod, v1, d1, acc and cnt unchanged. In-flight data resumes unchanged when stall drops.
- Back-to-back dumps on consecutive accepted cycles are legal. Each covers only its own samples.
- Throughput: one sample per cycle when stall=0.

## Configuration
- CORRELATOR_CHANNEL_SATURATE_EN defined:
  - acc clamps at 2^ACC_W−1 and cnt clamps at 2^CNT_W−1.
  - The snapshot arithmetic clamps the same way.
  - Saturated values persist until a dump or clr.
- Not defined: acc and cnt wrap modulo 2^ACC_W and 2^CNT_W.

## Test plan
- Basic correlation: clr, then 4 accepted samples with direct=3, delayed=5, then dump the cycle after the last sample → out_valid=1 two cycles after dump, out_acc=60, out_cnt=4, overrun=0. Hold out_ack=0 for 5 cycles → values stable; ack → out_valid=0.
- Same-cycle dump and stall:
  - Dump in the same cycle as a sample (7×7) after 2 samples of 1×1 → out_acc=51, out_cnt=3.
  - Next snapshot without further samples → out_acc=0, out_cnt=0.
  - stall=1 for 3 cycles mid-stream leaves the totals unchanged.
- Overrun: dump twice, 5 cycles apart, with out_ack=0 → first snapshot retained, overrun=1 after the second, acc restarts at 0. Dump with ack in the same load cycle → new snapshot loaded, out_valid stays 1, overrun stays 1 until clr.
- Saturation, DIM=16, ACC_W=32, samples 0xFFFF×0xFFFF:
  - Macro defined: out_acc=0xFFFFFFFF after 2 samples.
  - Macro undefined: out_acc=0xFFFC0002 after 2 samples (wrapped).
- Reset mid-operation: clr asserted with a dump in stage 1 and out_valid=1 → next cycle all outputs 0 and no snapshot appears afterwards.
